mode_controller: RTL and testbench
==================================

MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive cycles a synchronized button level must differ from its debounced level before being accepted; legal range >= 1.
REQ-002 Parameter TICK_DIV, default 25_000_000, clock cycles per tick period; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_mode  input  1  raw mode button, active-high, asynchronous to clk, may bounce.
REQ-006 btn_pause  input  1  raw pause button, active-high, asynchronous to clk, may bounce.
REQ-007 mode  output  2  selected display mode, 0..3, registered.
REQ-008 pause  output  1  pause state, 1 = paused, registered.
REQ-009 tick  output  1  one-cycle step pulse for LED pattern processors, registered.
REQ-010 mode_changed  output  1  one-cycle pulse on the edge where mode updates, registered.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL have an independent debounce counter, width $clog2(DEBOUNCE_CYCLES+1), and a debounced level register.
REQ-013 Debounce counter SHALL increment while synchronized level differs from debounced level and clear to 0 on any cycle they agree.
REQ-014 Debounced level SHALL take the synchronized value, and the counter SHALL clear, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-015 A press SHALL be a 0->1 transition of the debounced level; release SHALL have no effect; holding a button SHALL produce exactly one press.
REQ-016 A raw level held stable from before rising edge k SHALL be reflected in mode/pause after edge k+DEBOUNCE_CYCLES+2 (exactly DEBOUNCE_CYCLES+3 edges including edge k).
REQ-017 Any excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no press.
REQ-018 Mode press SHALL set mode to mode+1 modulo 4 (3 wraps to 0) and assert mode_changed for exactly that cycle.
REQ-019 Pause press SHALL toggle pause.
REQ-020 Prescaler counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be 1 for the one cycle following the edge where the counter wraps from TICK_DIV-1 to 0.
REQ-021 While pause = 1, prescaler SHALL hold its value and tick SHALL be 0; on unpause, counting SHALL resume from the held value.
REQ-022 Mode press SHALL clear the prescaler to 0 and force tick to 0 that cycle, so each new mode starts with a full period.
REQ-023 Simultaneous mode and pause presses SHALL both take effect on the same edge; prescaler clears (REQ-022) and the new pause value governs subsequent cycles.
REQ-024 Mode press while paused SHALL update mode and clear the prescaler; pause SHALL remain 1.

Reset
REQ-025 reset = 1 SHALL immediately force mode = 0, pause = 0, tick = 0, mode_changed = 0, and clear synchronizers, debounce counters, debounced levels and prescaler, independent of clk.
REQ-026 A button held high across reset deassertion SHALL be treated as a new press once debounced.

Verification (DEBOUNCE_CYCLES = 4, TICK_DIV = 5)
REQ-027 Reset then 30 idle cycles -> mode = 0, pause = 0, tick pulses every 5 cycles, mode_changed never asserts.
REQ-028 btn_mode high 3 cycles then low -> no mode change, no mode_changed pulse.
REQ-029 Four btn_mode presses, each high 10 cycles, low 10 cycles -> mode 1,2,3,0; four mode_changed pulses, each 7 edges after btn_mode rises; tick absent for 5 cycles after each change.
REQ-030 btn_pause press -> pause = 1, no tick for 50 cycles; second press -> pause = 0, first tick arrives after the remaining count from the held prescaler value.
REQ-031 btn_mode and btn_pause rise together -> mode increments and pause toggles on the same edge, prescaler = 0.
REQ-032 reset pulsed mid-debounce (btn_mode high 2 cycles) and mid-prescale -> all outputs 0 at once; btn_mode held through reset release -> mode = 1 exactly 7 edges after release.

Source files
------------

// File: rtl/mode_controller.sv
// Mode/pause front panel controller: synchronizes and debounces two buttons,
// cycles a 2-bit display mode, toggles pause and generates a pausable step tick.
module mode_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_pause,
    output logic [1:0] mode,
    output logic       pause,
    output logic       tick,
    output logic       mode_changed
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    // bit 0 = mode button, bit 1 = pause button
    logic [1:0]      btn_raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      deb_p2;
    logic [1:0]      deb_p3;
    logic [1:0]      press;
    logic            mode_press;
    logic            pause_press;
    logic [PS_W-1:0] ps_cnt;

    assign btn_raw = {btn_pause, btn_mode};

    // stage p0/p1: two-flop synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // stage p2: per-button debounce, level accepted when the counter would reach DEBOUNCE_CYCLES
    for (genvar i = 0; i < 2; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            lvl;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync_p1[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt <= '0;
                lvl <= sync_p1[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb_p2[i] = lvl;
    end

    assign press       = deb_p2 & ~deb_p3;
    assign mode_press  = press[0];
    assign pause_press = press[1];

    // stage p3: press edge detect, mode/pause state and tick prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_p3       <= '0;
            mode         <= 2'd0;
            pause        <= 1'b0;
            tick         <= 1'b0;
            mode_changed <= 1'b0;
            ps_cnt       <= '0;
        end else begin
            deb_p3       <= deb_p2;
            mode_changed <= mode_press;
            if (mode_press) begin
                mode <= mode + 2'd1;
            end
            if (pause_press) begin
                pause <= ~pause;
            end
            // an accepted pause press freezes the prescaler on its own edge, just as a mode press clears it
            if (mode_press) begin
                ps_cnt <= '0;
                tick   <= 1'b0;
            end else if (pause || pause_press) begin
                tick   <= 1'b0;
            end else if (ps_cnt == PS_LAST) begin
                ps_cnt <= '0;
                tick   <= 1'b1;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
                tick   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller with DEBOUNCE_CYCLES = 4, TICK_DIV = 5.
module tb_mode_controller;

    localparam int DB = 4;
    localparam int TD = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_pause;
    logic [1:0] mode;
    logic       pause;
    logic       tick;
    logic       mode_changed;

    int total      = 0;
    int bad        = 0;
    int cyc        = 0;
    int tick_cnt   = 0;
    int mc_cnt     = 0;
    int first_tick = -1;
    int found;

    mode_controller #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_pause   (btn_pause),
        .mode        (mode),
        .pause       (pause),
        .tick        (tick),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tick === 1'b1) begin
            tick_cnt++;
            if (first_tick < 0) first_tick = cyc;
        end
        if (mode_changed === 1'b1) mc_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        cyc        = 0;
        tick_cnt   = 0;
        mc_cnt     = 0;
        first_tick = -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
        #2;
        chk("rst_mode", 32'(mode), 0);
        chk("rst_pause", 32'(pause), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_mc", 32'(mode_changed), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // idle: ticks on edges 5,10,...,30 after release
        clr();
        steps(30);
        chk("idle_tick_cnt", tick_cnt, 6);
        chk("idle_first_tick", first_tick, 5);
        chk("idle_mc_cnt", mc_cnt, 0);
        chk("idle_mode", 32'(mode), 0);
        chk("idle_pause", 32'(pause), 0);

        // 3-cycle glitch must be rejected
        clr();
        btn_mode = 1'b1;
        steps(3);
        btn_mode = 1'b0;
        steps(12);
        chk("glitch_mode", 32'(mode), 0);
        chk("glitch_mc_cnt", mc_cnt, 0);

        // four presses: 1,2,3,0; change on 7th edge, tick 5 edges later
        for (int p = 0; p < 4; p++) begin
            clr();
            btn_mode = 1'b1;
            steps(6);
            chk("press_early_mode", 32'(mode), 32'(p));
            step();
            chk("press_mode", 32'(mode), 32'((p + 1) % 4));
            chk("press_mc", 32'(mode_changed), 1);
            chk("press_tick_clr", 32'(tick), 0);
            tick_cnt = 0;
            step();
            chk("press_mc_one_cycle", 32'(mode_changed), 0);
            steps(2);
            btn_mode = 1'b0;
            step();
            chk("press_tick_gap", tick_cnt, 0);
            step();
            chk("press_tick_full_period", 32'(tick), 1);
            steps(8);
            chk("press_mc_cnt", mc_cnt, 1);
        end

        // align to a tick so the prescaler is known to be 0
        found = 0;
        for (int i = 0; i < 2 * TD && found == 0; i++) begin
            step();
            if (tick === 1'b1) found = 1;
        end
        chk("tick_sync", found, 1);

        // pause: prescaler counts 1,2,3,4,0,1 then freezes at 1
        btn_pause = 1'b1;
        clr();
        steps(6);
        chk("pause_early", 32'(pause), 0);
        step();
        chk("pause_set", 32'(pause), 1);
        chk("pause_tick", 32'(tick), 0);
        steps(3);
        btn_pause = 1'b0;
        clr();
        steps(50);
        chk("paused_tick_cnt", tick_cnt, 0);
        chk("paused_hold", 32'(pause), 1);

        // unpause: held value 1, so first tick on the 4th edge
        btn_pause = 1'b1;
        steps(6);
        chk("unpause_early", 32'(pause), 1);
        step();
        chk("unpause_clr", 32'(pause), 0);
        chk("unpause_tick", 32'(tick), 0);
        clr();
        steps(3);
        chk("resume_gap", tick_cnt, 0);
        step();
        chk("resume_first_tick", 32'(tick), 1);
        steps(6);
        btn_pause = 1'b0;
        steps(10);

        // simultaneous presses
        btn_mode  = 1'b1;
        btn_pause = 1'b1;
        clr();
        steps(6);
        chk("both_early_mode", 32'(mode), 0);
        step();
        chk("both_mode", 32'(mode), 1);
        chk("both_pause", 32'(pause), 1);
        chk("both_mc", 32'(mode_changed), 1);
        chk("both_tick", 32'(tick), 0);
        steps(3);
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
        clr();
        steps(20);
        chk("both_paused_ticks", tick_cnt, 0);
        chk("both_mode_hold", 32'(mode), 1);

        // unpause after a cleared prescaler: full period before the tick
        btn_pause = 1'b1;
        steps(7);
        chk("both_unpause", 32'(pause), 0);
        clr();
        steps(4);
        chk("both_resume_gap", tick_cnt, 0);
        step();
        chk("both_resume_tick", 32'(tick), 1);
        steps(3);
        btn_pause = 1'b0;
        steps(10);

        // pause again so reset has something to clear
        btn_pause = 1'b1;
        steps(10);
        btn_pause = 1'b0;
        steps(10);
        chk("pre_rst_pause", 32'(pause), 1);
        chk("pre_rst_mode", 32'(mode), 1);

        // async reset mid-debounce, button held through release
        btn_mode = 1'b1;
        steps(2);
        reset = 1'b1;
        #1;
        chk("async_rst_mode", 32'(mode), 0);
        chk("async_rst_pause", 32'(pause), 0);
        chk("async_rst_tick", 32'(tick), 0);
        chk("async_rst_mc", 32'(mode_changed), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_mode", 32'(mode), 0);
        reset = 1'b0;
        clr();
        steps(6);
        chk("post_rst_early", 32'(mode), 0);
        step();
        chk("post_rst_mode", 32'(mode), 1);
        chk("post_rst_mc", 32'(mode_changed), 1);
        chk("post_rst_pause", 32'(pause), 0);
        btn_mode = 1'b0;
        steps(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
